dbg_dump: RTL and testbench

DBG_DUMP -- requirements
Module: dbg_dump

---
 rtl/dbg_pkg.sv | 38 +++
 rtl/dbg_sat_counter.sv | 35 +++
 rtl/dbg_dump.sv | 181 ++++++++++++++++++
 tb/tb_dbg_dump.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug dump block: FSM state type,
// header length and the frame-length derivation.
package dbg_pkg;

    // Frame sections, in the order they are streamed out.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_REG  = 2'd2,
        ST_MEM  = 2'd3
    } dump_state_e;

    // Header words: cycle count, stall count, flush count, PC.
    localparam int HDR_WORDS = 4;

    // Width of the free-running event counters.
    localparam int CNT_W = 32;

    // Bytes per data-memory word.
    localparam int MEM_WORD_BYTES = 4;

    // Total number of words in one dump frame.
    function automatic int frame_words(input int nreg, input int nmemw);
        return HDR_WORDS + nreg + nmemw;
    endfunction

    // Section that a given frame word index belongs to.
    function automatic dump_state_e section_of(input int idx, input int nreg);
        if (idx < HDR_WORDS) begin
            return ST_HDR;
        end else if (idx < HDR_WORDS + nreg) begin
            return ST_REG;
        end else begin
            return ST_MEM;
        end
    endfunction

endpackage

// File: rtl/dbg_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module dbg_sat_counter
    import dbg_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Increment when enabled, sticking at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register, cleared immediately by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/dbg_dump.sv
// Debug dump engine: keeps cycle/stall/flush counters and, on request,
// streams a frame of header, register-file and data-memory words over a
// valid/ready interface, one word per cycle when the consumer is ready.
module dbg_dump
    import dbg_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int NMEMW = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic        dump_req_i,
    output logic [4:0]  reg_addr_o,
    input  logic [31:0] reg_data_i,
    output logic [4:0]  mem_addr_o,
    input  logic [31:0] mem_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        out_last_o,
    output logic        busy_o
);

    localparam int FRAME_WORDS = frame_words(NREG, NMEMW);
    localparam int MEM_BASE    = HDR_WORDS + NREG;
    localparam int IDX_W       = $clog2(FRAME_WORDS);

    // Live counter values.
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Frame state: section of the presented word and its index in the frame.
    dump_state_e      state_q, state_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;

    // Registered output word and handshake flags.
    logic [31:0]      out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    // Read addresses for the word that will be loaded next.
    logic [4:0]       reg_addr_q, reg_addr_d;
    logic [4:0]       mem_addr_q, mem_addr_d;

    // Header values frozen at request acceptance.
    logic [31:0]      snap_cycle_q, snap_cycle_d;
    logic [31:0]      snap_stall_q, snap_stall_d;
    logic [31:0]      snap_flush_q, snap_flush_d;
    logic [31:0]      snap_pc_q, snap_pc_d;

    // Index arithmetic helpers.
    int               next_idx;
    int               fetch_idx;

    dbg_sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (1'b1),
        .count_o (cycle_cnt)
    );

    dbg_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (stall_i),
        .count_o (stall_cnt)
    );

    dbg_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (flush_i),
        .count_o (flush_cnt)
    );

    // Frame sequencing: accept in IDLE, advance one word per handshake,
    // return to IDLE on the transfer of the last word.
    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        snap_cycle_d = snap_cycle_q;
        snap_stall_d = snap_stall_q;
        snap_flush_d = snap_flush_q;
        snap_pc_d    = snap_pc_q;
        next_idx     = int'(word_idx_q) + 1;

        if (state_q == ST_IDLE) begin
            if (dump_req_i) begin
                snap_cycle_d = cycle_cnt;
                snap_stall_d = stall_cnt;
                snap_flush_d = flush_cnt;
                snap_pc_d    = pc_i;
                out_data_d   = cycle_cnt;
                out_valid_d  = 1'b1;
                out_last_d   = 1'b0;
                word_idx_d   = '0;
                state_d      = ST_HDR;
            end
        end else if (out_valid_q && out_ready_i) begin
            if (out_last_q) begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                word_idx_d  = '0;
            end else begin
                word_idx_d = IDX_W'(next_idx);
                state_d    = section_of(next_idx, NREG);
                out_last_d = (next_idx == FRAME_WORDS - 1);
                if (next_idx < HDR_WORDS) begin
                    case (next_idx)
                        1:       out_data_d = snap_stall_q;
                        2:       out_data_d = snap_flush_q;
                        3:       out_data_d = snap_pc_q;
                        default: out_data_d = snap_cycle_q;
                    endcase
                end else if (next_idx < MEM_BASE) begin
                    out_data_d = reg_data_i;
                end else begin
                    out_data_d = mem_data_i;
                end
            end
        end
    end

    // Point the read ports one word ahead so data is ready at load time.
    always_comb begin
        reg_addr_d = '0;
        mem_addr_d = '0;
        fetch_idx  = int'(word_idx_d) + 1;
        if ((fetch_idx >= HDR_WORDS) && (fetch_idx < MEM_BASE)) begin
            reg_addr_d = 5'(fetch_idx - HDR_WORDS);
        end
        if ((fetch_idx >= MEM_BASE) && (fetch_idx < FRAME_WORDS)) begin
            mem_addr_d = 5'((fetch_idx - MEM_BASE) * MEM_WORD_BYTES);
        end
    end

    // State, output and snapshot registers; reset aborts any frame.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            word_idx_q   <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            reg_addr_q   <= '0;
            mem_addr_q   <= '0;
            snap_cycle_q <= '0;
            snap_stall_q <= '0;
            snap_flush_q <= '0;
            snap_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            reg_addr_q   <= reg_addr_d;
            mem_addr_q   <= mem_addr_d;
            snap_cycle_q <= snap_cycle_d;
            snap_stall_q <= snap_stall_d;
            snap_flush_q <= snap_flush_d;
            snap_pc_q    <= snap_pc_d;
        end
    end

    assign reg_addr_o  = reg_addr_q;
    assign mem_addr_o  = mem_addr_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dbg_dump.sv
// Scoreboard bench for dbg_dump: requests push expected frames built from a
// behavioural model; a monitor pops and compares every transferred word.
module tb_dbg_dump;

    localparam int NREG  = 32;
    localparam int NMEMW = 8;
    localparam int FRAME = 4 + NREG + NMEMW;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] pc_i;
    logic        dump_req_i;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_i;
    logic [4:0]  mem_addr_o;
    logic [31:0] mem_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic        out_last_o;
    logic        busy_o;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          idx;
    } exp_t;

    exp_t        expQ[$];
    int          nChecks = 0;
    int          nFails  = 0;

    logic [31:0] regFile  [0:NREG-1];
    logic [7:0]  memBytes [0:4*NMEMW-1];

    logic [31:0] mCycle, mStall, mFlush;
    logic        randReady = 1'b0;

    int          tbCyc = 0;
    int          monXfers = 0;
    int          monFirstCyc = 0;
    int          monSpan = 0;
    int          monLastCount = 0;
    logic [31:0] capWords [0:FRAME-1];
    logic        heldValid = 1'b0;
    logic [31:0] heldData;
    logic        heldLast;

    dbg_dump #(.NREG(NREG), .NMEMW(NMEMW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .pc_i        (pc_i),
        .dump_req_i  (dump_req_i),
        .reg_addr_o  (reg_addr_o),
        .reg_data_i  (reg_data_i),
        .mem_addr_o  (mem_addr_o),
        .mem_data_i  (mem_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Combinational register file and little-endian data memory.
    assign reg_data_i = regFile[reg_addr_o];
    assign mem_data_i = {memBytes[mem_addr_o + 5'd3], memBytes[mem_addr_o + 5'd2],
                         memBytes[mem_addr_o + 5'd1], memBytes[mem_addr_o]};

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic failTimeout(input string name, input int cycles);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: still waiting after %0d cycles, expected completion", name, cycles);
    endtask

    // Model counters: each negedge accounts for the upcoming rising edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            mCycle = '0;
            mStall = '0;
            mFlush = '0;
        end else begin
            mCycle = satInc(mCycle);
            if (stall_i) mStall = satInc(mStall);
            if (flush_i) mFlush = satInc(mFlush);
        end
    end

    // Monitor: hold-stability while back-pressured, then pop and compare transfers.
    always @(negedge clk_i) begin
        tbCyc++;
        if (!rst_i) begin
            heldValid = 1'b0;
        end else begin
            if (heldValid) begin
                checkOutput("hold_valid", {31'b0, out_valid_o}, 32'd1);
                checkOutput("hold_data", out_data_o, heldData);
                checkOutput("hold_last", {31'b0, out_last_o}, {31'b0, heldLast});
            end
            if (out_valid_o && out_ready_i) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_word_valid", {31'b0, out_valid_o}, 32'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput($sformatf("word_data[%0d]", e.idx), out_data_o, e.data);
                    checkOutput($sformatf("word_last[%0d]", e.idx), {31'b0, out_last_o}, {31'b0, e.last});
                    capWords[e.idx] = out_data_o;
                    if (e.idx == 0) monFirstCyc = tbCyc;
                    if (out_last_o) monLastCount++;
                    if (e.last) monSpan = tbCyc - monFirstCyc + 1;
                    monXfers++;
                end
            end
            heldValid = out_valid_o && !out_ready_i;
            heldData  = out_data_o;
            heldLast  = out_last_o;
        end
    end

    // Build the expected frame from the model counters and memory contents.
    task automatic pushFrame(input logic [31:0] pcVal);
        exp_t e;
        for (int i = 0; i < FRAME; i++) begin
            if (i == 0)               e.data = mCycle;
            else if (i == 1)          e.data = mStall;
            else if (i == 2)          e.data = mFlush;
            else if (i == 3)          e.data = pcVal;
            else if (i < 4 + NREG)    e.data = regFile[i - 4];
            else begin
                int b;
                b = (i - 4 - NREG) * 4;
                e.data = {memBytes[b + 3], memBytes[b + 2], memBytes[b + 1], memBytes[b]};
            end
            e.last = (i == FRAME - 1);
            e.idx  = i;
            expQ.push_back(e);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    // Issue one accepted dump request (DUT idle) and queue its frame.
    task automatic applyStimulus(input logic [31:0] pcVal);
        monXfers     = 0;
        monLastCount = 0;
        monSpan      = 0;
        pc_i         = pcVal;
        dump_req_i   = 1'b1;
        pushFrame(pcVal);
        waitCycles(1);
        dump_req_i = 1'b0;
        pc_i       = $urandom;
        checkOutput("valid_after_req", {31'b0, out_valid_o}, 32'd1);
        checkOutput("busy_after_req", {31'b0, busy_o}, 32'd1);
    endtask

    task automatic waitFrameDone(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || busy_o || out_valid_o) && n < 600) begin
            waitCycles(1);
            n++;
        end
        if (n >= 600) failTimeout(name, n);
        checkOutput({name, "_xfers"}, monXfers, FRAME);
        checkOutput({name, "_last_count"}, monLastCount, 32'd1);
    endtask

    task automatic waitXfers(input int target, input string name);
        int n;
        n = 0;
        while (monXfers < target && n < 400) begin
            waitCycles(1);
            n++;
        end
        if (n >= 400) failTimeout(name, n);
    endtask

    initial begin
        rst_i      = 1'b1;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        pc_i       = '0;
        dump_req_i = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < NREG; i++) regFile[i] = $urandom;
        for (int i = 0; i < 4 * NMEMW; i++) memBytes[i] = 8'($urandom);
        #1 rst_i = 1'b0;

        fork
            forever begin
                @(posedge clk_i);
                #2;
                out_ready_i = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        join_none

        // Reset state.
        waitCycles(3);
        checkOutput("rst_valid", {31'b0, out_valid_o}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("rst_last", {31'b0, out_last_o}, 32'd0);
        checkOutput("rst_data", out_data_o, 32'd0);
        checkOutput("rst_reg_addr", {27'b0, reg_addr_o}, 32'd0);
        checkOutput("rst_mem_addr", {27'b0, mem_addr_o}, 32'd0);
        rst_i = 1'b1;

        // Counters after idle, stall and flush activity; continuous ready.
        $display("[TB] counters and continuous-ready frame");
        waitCycles(10);
        stall_i = 1'b1;
        waitCycles(3);
        stall_i = 1'b0;
        flush_i = 1'b1;
        waitCycles(2);
        flush_i = 1'b0;
        applyStimulus(32'h0000_1000);
        waitFrameDone("frame1");
        checkOutput("frame1_span", monSpan, FRAME);
        checkOutput("frame1_cycle_ge10", {31'b0, capWords[0] >= 32'd10}, 32'd1);
        checkOutput("frame1_stall", capWords[1], 32'd3);
        checkOutput("frame1_flush", capWords[2], 32'd2);

        // Known register/memory/PC contents.
        $display("[TB] known contents frame");
        regFile[8]  = 32'd5;
        memBytes[0] = 8'd5;
        memBytes[1] = 8'd0;
        memBytes[2] = 8'd0;
        memBytes[3] = 8'd0;
        waitCycles(2);
        applyStimulus(32'h0000_001C);
        waitFrameDone("frame2");
        checkOutput("frame2_pc_word", capWords[3], 32'd28);
        checkOutput("frame2_r8_word", capWords[12], 32'd5);
        checkOutput("frame2_mem0_word", capWords[36], 32'd5);

        // Random back-pressure.
        $display("[TB] random ready frame");
        for (int i = 0; i < NREG; i++) regFile[i] = $urandom;
        randReady = 1'b1;
        waitCycles(1);
        applyStimulus($urandom);
        waitFrameDone("frame3");
        randReady = 1'b0;
        waitCycles(2);

        // Requests while busy and at the final transfer are ignored.
        $display("[TB] ignored requests");
        applyStimulus($urandom);
        waitXfers(20, "wait_word20");
        dump_req_i = 1'b1;
        waitCycles(1);
        dump_req_i = 1'b0;
        begin
            int n;
            n = 0;
            while (!(out_valid_o && out_last_o) && n < 200) begin
                waitCycles(1);
                n++;
            end
            if (n >= 200) failTimeout("wait_last_word", n);
        end
        dump_req_i = 1'b1;
        waitCycles(1);
        dump_req_i = 1'b0;
        checkOutput("after_last_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("after_last_valid", {31'b0, out_valid_o}, 32'd0);
        waitCycles(6);
        checkOutput("no_second_frame_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("frame4_xfers", monXfers, FRAME);
        checkOutput("frame4_queue_empty", expQ.size(), 32'd0);

        // Reset in the middle of the register section.
        $display("[TB] reset during frame");
        applyStimulus($urandom);
        waitXfers(10, "wait_reg_state");
        rst_i = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'b0, out_valid_o}, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("midrst_data", out_data_o, 32'd0);
        checkOutput("midrst_reg_addr", {27'b0, reg_addr_o}, 32'd0);
        expQ.delete();
        waitCycles(2);
        rst_i = 1'b1;
        waitCycles(4);
        applyStimulus(32'h0000_0040);
        waitFrameDone("frame5");
        checkOutput("frame5_cycle", capWords[0], 32'd4);
        checkOutput("frame5_stall", capWords[1], 32'd0);
        checkOutput("frame5_flush", capWords[2], 32'd0);

        // Stall counter saturation.
        $display("[TB] stall counter saturation");
        force dut.u_stall_cnt.count_q = 32'hFFFF_FFFE;
        mStall  = 32'hFFFF_FFFE;
        stall_i = 1'b1;
        waitCycles(1);
        release dut.u_stall_cnt.count_q;
        waitCycles(2);
        stall_i = 1'b0;
        waitCycles(1);
        applyStimulus($urandom);
        waitFrameDone("frame6");
        checkOutput("frame6_stall_sat", capWords[1], 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
        nFails++;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
